// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: FSM state encoding and default operand width shared by the ALU sequential units
package booth_mult_pkg;
    localparam int ALU_WIDTH = 8;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (add/subtract selection, then arithmetic right shift)
module booth_step
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;
    always_comb begin
        m_ext = {m[WIDTH-1], m};
        sum = {q[0], q_m1} == 2'b01 ? acc + m_ext :
              {q[0], q_m1} == 2'b10 ? acc - m_ext : acc;
        {acc_next, q_next, q_m1_next} = {sum[WIDTH], sum, q};
    end
endmodule

// File: rtl/booth_mult.sv
// booth_mult: sequential signed radix-2 Booth multiplier, one step per clock, start/done handshake
module booth_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [1:0]       state, state_next;
    logic [WIDTH:0]   acc, acc_next;
    logic [WIDTH-1:0] q, q_next, m;
    logic             q_m1, q_m1_next;
    logic [CW-1:0]    count;
    logic             load, step;
    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q),
        .q_m1     (q_m1),
        .m        (m),
        .acc_next (acc_next),
        .q_next   (q_next),
        .q_m1_next(q_m1_next)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end
    // count still holds the pre-increment value on the last step
    always_comb begin
        state_next = state == IDLE ? (start ? CALC : IDLE) :
                     state == CALC ? (count == CW'(WIDTH - 1) ? DONE : CALC) : IDLE;
    end
    always_comb begin
        busy = state != IDLE;
        load = state == IDLE && start;
        step = state == CALC;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            if (load) begin
                acc   <= '0;
                q     <= b;
                m     <= a;
                q_m1  <= 1'b0;
                count <= '0;
            end else if (step) begin
                acc   <= acc_next;
                q     <= q_next;
                q_m1  <= q_m1_next;
                count <= count + 1'b1;
            end
            done <= state == DONE;
            if (state == DONE) product <= {acc[WIDTH-1:0], q};
        end
    end
endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed self-checking bench for booth_mult at WIDTH = 8
module tb_booth_mult;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  a, b;
    logic [15:0] product;
    logic        done, busy;
    int checks = 0;
    int passed = 0;

    booth_mult #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .product(product),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // returns edges until done is seen; 40 means it never came
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (product !== 16'h0000) $display("FAIL reset_product got %h want 0000", product); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        issue(8'd7, 8'hFD);
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (n < 9) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy edge %0d got busy=%b done=%b want 1 0", n, busy, done);
                else passed++;
            end else begin
                checks++; if (done !== 1'b1) $display("FAIL basic_done_e9 got %b want 1", done); else passed++;
                checks++; if (busy !== 1'b0) $display("FAIL basic_busy_e9 got %b want 0", busy); else passed++;
                checks++; if (product !== 16'hFFEB) $display("FAIL basic_product got %h want ffeb", product); else passed++;
            end
        end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_corners;
        int n;
        issue(8'h80, 8'h80);
        wait_done(n);
        checks++; if (n !== 9 || product !== 16'h4000) $display("FAIL min_sq got %h after %0d want 4000 after 9", product, n); else passed++;
        issue(8'h80, 8'h7F);
        wait_done(n);
        checks++; if (n !== 9 || product !== 16'hC080) $display("FAIL min_max got %h after %0d want c080 after 9", product, n); else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (product !== 16'hC080) $display("FAIL hold_after got %h want c080", product); else passed++;
    endtask

    task automatic test_hold;
        int n;
        issue(8'h00, 8'hFF);
        wait_done(n);
        checks++; if (n !== 9 || product !== 16'h0000) $display("FAIL zero_prod got %h after %0d want 0000 after 9", product, n); else passed++;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (product !== 16'h0000 || done !== 1'b0) $display("FAIL zero_hold got %h done=%b want 0000 0", product, done); else passed++;
        issue(8'h01, 8'h01);
        wait_done(n);
        checks++; if (n !== 9 || product !== 16'h0001) $display("FAIL one_prod got %h after %0d want 0001 after 9", product, n); else passed++;
    endtask

    task automatic test_ignore_start;
        int n;
        int pulses;
        issue(8'd5, 8'd6);
        @(posedge clk);
        @(posedge clk);
        #1;
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        checks++; if (n !== 6) $display("FAIL busy_start_latency got %0d want 6", n); else passed++;
        checks++; if (product !== 16'd30) $display("FAIL busy_start_product got %0d want 30", product); else passed++;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checks++; if (pulses !== 0 || product !== 16'd30) $display("FAIL busy_start_ignored got %0d pulses product %0d want 0 30", pulses, product); else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        int pulses;
        issue(8'd12, 8'd12);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        checks++; if (product !== 16'h0000) $display("FAIL midreset_product got %h want 0000", product); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midreset_flags got busy=%b done=%b want 0 0", busy, done); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL midreset_no_done got %0d active cycles want 0", pulses); else passed++;
        issue(8'd12, 8'd12);
        wait_done(n);
        checks++; if (n !== 9 || product !== 16'd144) $display("FAIL midreset_rerun got %0d after %0d want 144 after 9", product, n); else passed++;
    endtask

    task automatic test_back_to_back;
        int n;
        issue(8'd3, 8'd4);
        wait_done(n);
        checks++; if (n !== 9 || product !== 16'd12) $display("FAIL b2b_first got %0d after %0d want 12 after 9", product, n); else passed++;
        a = 8'hFB;
        b = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        checks++; if (n !== 9 || product !== 16'hFFE7) $display("FAIL b2b_second got %h after %0d want ffe7 after 9", product, n); else passed++;
    endtask

    task automatic test_sweep;
        logic [7:0] vals [6] = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F};
        logic [7:0] x, y;
        logic [15:0] exp;
        int p, n;
        for (int k = 0; k < 36 + 150; k++) begin
            if (k < 36) begin
                x = vals[k / 6];
                y = vals[k % 6];
            end else begin
                x = 8'($urandom_range(0, 255));
                y = 8'($urandom_range(0, 255));
            end
            p = int'($signed(x)) * int'($signed(y));
            exp = p[15:0];
            issue(x, y);
            wait_done(n);
            checks++;
            if (n !== 9 || product !== exp) $display("FAIL sweep %h*%h got %h after %0d want %h after 9", x, y, product, n, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_corners;
        test_hold;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_sweep;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
